spi_slave_multichannel: RTL and testbench

- Parametrised successor to the single-word SPI receiver.
- Receives addressed frames over a clock/data-only SPI link (no chip select) from the control MCU. Each frame carries an ADDR_BITS address followed by a DATA_WIDTH payload.
- Writes the payload into one of NUM_CHANNELS held output registers (oscillator pitch, waveform, level, ...).
- Adds input synchronisation, selectable bit order, range checking, timeout error reporting and per-channel update strobes.

---
 rtl/spi_slave_multichannel.sv | 200 ++++++++++++++++++++
 tb/tb_spi_slave_multichannel.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_multichannel.sv
// Addressed SPI frame receiver writing NUM_CHANNELS held output registers.
// Define SPI_SLAVE_PARITY_EN to append an even-parity bit to every frame.
module spi_slave_multichannel #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_BITS    = 4,
  parameter int NUM_CHANNELS = 4,
  parameter int LSB_FIRST    = 1,
  parameter int IDLETIME     = 511
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               spi_clock_in,
  input  logic                               spi_data_in,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] channel_data,
  output logic [NUM_CHANNELS-1:0]            channel_valid,
  output logic                               data_received,
  output logic                               frame_error,
  output logic                               busy
);

`ifdef SPI_SLAVE_PARITY_EN
  localparam int FRAME_BITS = ADDR_BITS + DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = ADDR_BITS + DATA_WIDTH;
`endif
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int IW = $clog2(IDLETIME + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WAIT,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]            r_sclk;
  logic [1:0]            r_sdat;
  logic [BW-1:0]         r_bitcnt;
  logic [IW-1:0]         r_idle;
  logic [FRAME_BITS-1:0] r_frame;

  logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_chan;
  logic [NUM_CHANNELS-1:0]            r_valid;
  logic                               r_rx;
  logic                               r_err;

  logic                    w_sclk;
  logic                    w_sdat;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_sample;
  logic                    w_idle_clr;
  logic                    w_idle_inc;
  logic                    w_abort;
  logic                    w_last;
  logic                    w_timeout;
  logic [BW-1:0]           w_bitidx;
  logic [ADDR_BITS-1:0]    w_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [NUM_CHANNELS-1:0] w_sel;
  logic                    w_par_ok;
  logic                    w_commit;
  logic                    w_ok;
  logic                    w_bad;

  assign w_sclk = r_sclk[1];
  assign w_sdat = r_sdat[1];
  assign w_rise = r_sclk[1] & ~r_sclk[2];
  assign w_fall = ~r_sclk[1] & r_sclk[2];

  assign w_last    = (w_bitidx == BW'(FRAME_BITS - 1));
  assign w_timeout = (r_idle >= IW'(IDLETIME));
  assign w_bitidx  = (r_state == S_IDLE) ? '0 : r_bitcnt;

  // A clock already high on entry to IDLE (after an abort) is ignored
  // until it has been seen low again.
  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_idle_clr  = 1'b0;
    w_idle_inc  = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_RECV;
          w_sample    = 1'b1;
          w_idle_clr  = 1'b1;
        end
      end
      S_RECV: begin
        if (w_rise) begin
          w_sample   = 1'b1;
          w_idle_clr = 1'b1;
          if (w_last) w_state_nxt = S_WAIT;
        end else if (w_fall) begin
          w_idle_clr = 1'b1;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_idle_inc = 1'b1;
        end
      end
      S_WAIT: begin
        if (!w_sclk) begin
          w_state_nxt = S_COMMIT;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_idle_inc = 1'b1;
        end
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_sel  = '0;
    for (int i = 0; i < ADDR_BITS; i++)
      w_addr[i] = (LSB_FIRST != 0) ? r_frame[i]
                                   : r_frame[ADDR_BITS-1-i];
    for (int i = 0; i < DATA_WIDTH; i++)
      w_data[i] = (LSB_FIRST != 0) ? r_frame[ADDR_BITS+i]
                                   : r_frame[ADDR_BITS+DATA_WIDTH-1-i];
    for (int k = 0; k < NUM_CHANNELS; k++)
      w_sel[k] = (w_addr == ADDR_BITS'(k));
  end

`ifdef SPI_SLAVE_PARITY_EN
  assign w_par_ok = ~(^r_frame);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_commit = (r_state == S_COMMIT);
  assign w_ok     = w_commit & (|w_sel) & w_par_ok;
  assign w_bad    = w_commit & ~((|w_sel) & w_par_ok);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sclk   <= '0;
      r_sdat   <= '0;
      r_bitcnt <= '0;
      r_idle   <= '0;
      r_frame  <= '0;
      r_chan   <= '0;
      r_valid  <= '0;
      r_rx     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sclk <= {r_sclk[1:0], spi_clock_in};
      r_sdat <= {r_sdat[0], spi_data_in};

      if (w_sample)
        r_bitcnt <= w_bitidx + BW'(1);
      else if (w_commit || w_abort)
        r_bitcnt <= '0;

      for (int i = 0; i < FRAME_BITS; i++)
        if (w_sample && (w_bitidx == BW'(i)))
          r_frame[i] <= w_sdat;

      if (w_idle_clr || w_abort)
        r_idle <= '0;
      else if (w_idle_inc)
        r_idle <= r_idle + IW'(1);

      r_valid <= w_ok ? w_sel : '0;
      r_rx    <= w_ok;
      r_err   <= w_abort | w_bad;

      for (int k = 0; k < NUM_CHANNELS; k++)
        if (w_ok && w_sel[k])
          r_chan[k*DATA_WIDTH +: DATA_WIDTH] <= w_data;
    end
  end

  assign channel_data  = r_chan;
  assign channel_valid = r_valid;
  assign data_received = r_rx;
  assign frame_error   = r_err;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_slave_multichannel.sv
// Bench for spi_slave_multichannel: LSB-first and MSB-first instances
// receive the same logical frames; a channel-array model predicts results.
module tb_spi_slave_multichannel;

  localparam int DW = 16;
  localparam int AB = 4;
  localparam int NC = 4;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int FB = AB + DW + 1;
`else
  localparam int FB = AB + DW;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sclk  = 1'b0;
  logic sd_l  = 1'b0;
  logic sd_m  = 1'b0;

  logic [NC*DW-1:0] cd0, cd1;
  logic [NC-1:0]    cv0, cv1;
  logic             rx0, rx1, er0, er1, bz0, bz1;

  spi_slave_multichannel #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_CHANNELS(NC),
    .LSB_FIRST(1), .IDLETIME(511)
  ) u_lsb (
    .clock(clock), .reset(reset),
    .spi_clock_in(sclk), .spi_data_in(sd_l),
    .channel_data(cd0), .channel_valid(cv0),
    .data_received(rx0), .frame_error(er0), .busy(bz0)
  );

  spi_slave_multichannel #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_CHANNELS(NC),
    .LSB_FIRST(0), .IDLETIME(511)
  ) u_msb (
    .clock(clock), .reset(reset),
    .spi_clock_in(sclk), .spi_data_in(sd_m),
    .channel_data(cd1), .channel_valid(cv1),
    .data_received(rx1), .frame_error(er1), .busy(bz1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  int         rx_cnt[2]  = '{0, 0};
  int         err_cnt[2] = '{0, 0};
  int         bad_cnt[2] = '{0, 0};
  int         rx_cyc[2]  = '{0, 0};
  logic [3:0] last_v[2]  = '{4'h0, 4'h0};
  logic [63:0] last_d[2] = '{64'h0, 64'h0};
  logic       prev_rx[2]  = '{1'b0, 1'b0};
  logic       prev_err[2] = '{1'b0, 1'b0};

  logic [63:0] mdl = '0;
  int exp_rx  = 0;
  int exp_err = 0;
  int t_fall  = 0;

  task automatic mon(input int i, input logic [63:0] d,
                     input logic [3:0] v, input logic r, input logic e);
    if (r) begin
      rx_cnt[i]++;
      rx_cyc[i] = cyc;
      last_v[i] = v;
      last_d[i] = d;
    end else if (v != 4'h0) begin
      bad_cnt[i]++;
    end
    if (e) err_cnt[i]++;
    if ((r && prev_rx[i]) || (e && prev_err[i]) || (r && e))
      bad_cnt[i]++;
    prev_rx[i]  = r;
    prev_err[i] = e;
  endtask

  always @(negedge clock) begin
    mon(0, cd0, cv0, rx0, er0);
    mon(1, cd1, cv1, rx1, er1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives nb bits (20-clock SPI period); a full frame ends with the clock low.
  task automatic send(input logic [3:0] a, input logic [15:0] d,
                      input int nb, input bit flip);
    logic [FB-1:0] fl, fm;
    fl = '0;
    fm = '0;
    for (int i = 0; i < AB; i++) begin
      fl[i] = a[i];
      fm[i] = a[AB-1-i];
    end
    for (int i = 0; i < DW; i++) begin
      fl[AB+i] = d[i];
      fm[AB+i] = d[DW-1-i];
    end
`ifdef SPI_SLAVE_PARITY_EN
    fl[FB-1] = (^{a, d}) ^ flip;
    fm[FB-1] = (^{a, d}) ^ flip;
`endif
    for (int b = 0; b < nb; b++) begin
      sclk = 1'b0;
      sd_l = fl[b];
      sd_m = fm[b];
      tick(10);
      sclk = 1'b1;
      tick(10);
    end
    if (nb == FB) begin
      sclk   = 1'b0;
      t_fall = cyc;
    end
  endtask

  task automatic predict(input int a, input logic [15:0] d,
                         input bit bad_par);
    if (a < NC && !bad_par) begin
      mdl[a*DW +: DW] = d;
      exp_rx++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic settle(input string tag, input int a, input bit bad_par);
    logic [3:0] oh;
    bit         ok;
    ok = (a < NC) && !bad_par;
    oh = 4'b0001 << a;
    tick(10);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s/rx%0d", tag, i), 64'(rx_cnt[i]), 64'(exp_rx));
      chk($sformatf("%s/err%0d", tag, i), 64'(err_cnt[i]), 64'(exp_err));
      chk($sformatf("%s/pulse%0d", tag, i), 64'(bad_cnt[i]), 64'(0));
      chk($sformatf("%s/data%0d", tag, i), i == 0 ? cd0 : cd1, mdl);
      if (ok) begin
        chk($sformatf("%s/valid%0d", tag, i), 64'(last_v[i]), 64'(oh));
        chk($sformatf("%s/sdata%0d", tag, i), last_d[i], mdl);
        chk($sformatf("%s/lat%0d", tag, i),
            64'(rx_cyc[i] - t_fall), 64'(4));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ra;
    logic [15:0] rd;

    tick(3);
    chk("rst/cd0", cd0, 64'h0);
    chk("rst/cd1", cd1, 64'h0);
    chk("rst/outs", 64'({cv0, cv1, rx0, rx1, er0, er1, bz0, bz1}), 64'h0);
    reset = 1'b1;
    tick(3);

    send(4'd2, 16'hA55A, FB, 1'b0);
    predict(2, 16'hA55A, 1'b0);
    settle("a2", 2, 1'b0);

    send(4'd1, 16'h1234, FB, 1'b0);
    predict(1, 16'h1234, 1'b0);
    settle("a1", 1, 1'b0);

    send(4'd7, 16'hCAFE, FB, 1'b0);
    predict(7, 16'hCAFE, 1'b0);
    settle("a7", 7, 1'b0);

    // Clock stopped high after bit 9; the slave must give up on its own.
    send(4'd3, 16'h3C3C, 9, 1'b0);
    tick(290);
    chk("to/busy0", 64'(bz0), 64'(1));
    chk("to/busy1", 64'(bz1), 64'(1));
    tick(300);
    exp_err++;
    chk("to/idle0", 64'(bz0), 64'(0));
    chk("to/idle1", 64'(bz1), 64'(0));
    chk("to/err0", 64'(err_cnt[0]), 64'(exp_err));
    chk("to/err1", 64'(err_cnt[1]), 64'(exp_err));
    sclk = 1'b0;
    tick(10);
    chk("to/low0", 64'(bz0), 64'(0));
    send(4'd0, 16'hBEEF, FB, 1'b0);
    predict(0, 16'hBEEF, 1'b0);
    settle("beef", 0, 1'b0);

    send(4'd3, 16'h00FF, FB, 1'b0);
    predict(3, 16'h00FF, 1'b0);
    settle("a3", 3, 1'b0);

    send(4'd1, 16'h7777, 5, 1'b0);
    sclk = 1'b0;
    tick(3);
    chk("mid/busy", 64'({bz0, bz1}), 64'(2'b11));
    reset = 1'b0;
    #1;
    mdl = '0;
    chk("mid/cd0", cd0, 64'h0);
    chk("mid/cd1", cd1, 64'h0);
    chk("mid/outs", 64'({cv0, cv1, rx0, rx1, er0, er1, bz0, bz1}), 64'h0);
    tick(3);
    reset = 1'b1;
    tick(3);
    send(4'd1, 16'h5A5A, FB, 1'b0);
    predict(1, 16'h5A5A, 1'b0);
    settle("post", 1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      ra = 4'($urandom_range(0, 15));
      rd = 16'($urandom);
      send(ra, rd, FB, 1'b0);
      predict(int'(ra), rd, 1'b0);
      settle($sformatf("rnd%0d", n), int'(ra), 1'b0);
    end

`ifdef SPI_SLAVE_PARITY_EN
    send(4'd0, 16'h0001, FB, 1'b0);
    predict(0, 16'h0001, 1'b0);
    settle("par_ok", 0, 1'b0);
    send(4'd0, 16'h0001, FB, 1'b1);
    predict(0, 16'h0001, 1'b1);
    settle("par_bad", 0, 1'b1);
    send(4'd0, 16'hFFFE, FB, 1'b1);
    predict(0, 16'hFFFE, 1'b1);
    settle("par_bad2", 0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
